// File: rtl/sys_clk_gen_pkg.sv
// Shared types and helpers for the multi-channel clock-divider generator.
// Used by sys_clk_gen_ch and sys_clk_div_gen (optional feature macro: CLKGEN_RELOCK_CNT_EN).
package sys_clk_gen_pkg;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_WAIT   = 2'd1,
        S_LOCKED = 2'd2
    } state_e;

    localparam int MIN_DIV = 2;

    // Channel-select width; a single channel still needs a 1-bit select.
    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sys_clk_gen_ch.sv
// One divider channel: wrap-around counter, phase-offset load value and
// registered outclk/outclk_en decode.
module sys_clk_gen_ch
    import sys_clk_gen_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic [DIV_W-1:0] phase_i,
    output logic             outclk_o,
    output logic             outclk_en_o
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] load_val;
    logic             outclk_q;
    logic             outclk_d;
    logic             outclk_en_q;
    logic             outclk_en_d;

    // (div - phase) mod div; phase < div is guaranteed by the config checker.
    always_comb begin
        load_val = '0;
        if (phase_i != '0) begin
            load_val = div_i - phase_i;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val;
        end else if (cnt_q == div_i - ONE) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_comb begin
        outclk_d    = 1'b0;
        outclk_en_d = 1'b0;
        if (!load_i) begin
            outclk_d    = (cnt_q < (div_i >> 1));
            outclk_en_d = (cnt_q == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            cnt_q       <= '0;
            outclk_q    <= 1'b0;
            outclk_en_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            outclk_q    <= outclk_d;
            outclk_en_q <= outclk_en_d;
        end
    end

    assign outclk_o    = outclk_q;
    assign outclk_en_o = outclk_en_q;

endmodule

// File: rtl/sys_clk_div_gen.sv
// Multi-channel clock divider: FSM, lock counter, shadow config registers and
// config checker. Optional relock counter enabled by CLKGEN_RELOCK_CNT_EN.
module sys_clk_div_gen
    import sys_clk_gen_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 16,
    parameter int LOCK_CYCLES = 16,
    parameter int DEF_DIV     = 2
) (
    input  logic                      refclk,
    input  logic                      rst,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [ch_w(NUM_CH)-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]          cfg_div,
    input  logic [DIV_W-1:0]          cfg_phase,
    output logic                      cfg_err,
    output logic [NUM_CH-1:0]         outclk,
    output logic [NUM_CH-1:0]         outclk_en,
    output logic                      locked
`ifdef CLKGEN_RELOCK_CNT_EN
    ,
    output logic [15:0]               relock_cnt
`endif
);

    localparam int CH_W = ch_w(NUM_CH);
    localparam int LCW  = $clog2(LOCK_CYCLES + 1);

    generate
        if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
            $error("NUM_CH must be in 1..8");
        end
        if (LOCK_CYCLES < 1) begin : g_bad_lock
            $error("LOCK_CYCLES must be >= 1");
        end
        if (DEF_DIV < MIN_DIV) begin : g_bad_def_div
            $error("DEF_DIV must be >= 2");
        end
    endgenerate

    state_e           state_q;
    state_e           state_d;
    logic [LCW-1:0]   lock_cnt_q;
    logic [LCW-1:0]   lock_cnt_d;
    logic             cfg_err_q;
    logic             ch_load;
    logic             xfer;
    logic             cfg_legal;
    logic             accept;
    logic             lock_done;
    logic [7:0]       ch_ext;

    logic [DIV_W-1:0] div_q   [NUM_CH];
    logic [DIV_W-1:0] phase_q [NUM_CH];

    // Config legality: ratio, phase range and channel index.
    always_comb begin
        ch_ext    = 8'(cfg_ch);
        cfg_legal = (cfg_div >= DIV_W'(MIN_DIV))
                 && (cfg_phase < cfg_div)
                 && (ch_ext < 8'(NUM_CH));
    end

    assign xfer      = cfg_valid && cfg_ready;
    assign accept    = xfer && cfg_legal;
    assign lock_done = (lock_cnt_q == LCW'(LOCK_CYCLES - 1));

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // A legal transfer always wins over lock completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:   state_d = S_WAIT;
            S_WAIT: begin
                if (accept) begin
                    state_d = S_LOAD;
                end else if (lock_done) begin
                    state_d = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (accept) begin
                    state_d = S_LOAD;
                end
            end
            default:  state_d = S_LOAD;
        endcase
    end

    always_comb begin
        cfg_ready = (state_q != S_LOAD);
        locked    = (state_q == S_LOCKED);
        ch_load   = (state_q == S_LOAD);
    end

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            S_LOAD:  lock_cnt_d = '0;
            S_WAIT:  lock_cnt_d = lock_cnt_q + LCW'(1);
            default: lock_cnt_d = lock_cnt_q;
        endcase
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_cnt_q <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            cfg_err_q  <= xfer && !cfg_legal;
        end
    end

    assign cfg_err = cfg_err_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            always_ff @(posedge refclk) begin
                if (rst) begin
                    div_q[gi]   <= DIV_W'(DEF_DIV);
                    phase_q[gi] <= '0;
                end else if (accept && (cfg_ch == CH_W'(gi))) begin
                    div_q[gi]   <= cfg_div;
                    phase_q[gi] <= cfg_phase;
                end
            end

            sys_clk_gen_ch #(
                .DIV_W (DIV_W)
            ) u_ch (
                .clk_i       (refclk),
                .srst_i      (rst),
                .load_i      (ch_load),
                .div_i       (div_q[gi]),
                .phase_i     (phase_q[gi]),
                .outclk_o    (outclk[gi]),
                .outclk_en_o (outclk_en[gi])
            );
        end
    endgenerate

`ifdef CLKGEN_RELOCK_CNT_EN
    logic [15:0] relock_cnt_q;

    always_ff @(posedge refclk) begin
        if (rst) begin
            relock_cnt_q <= '0;
        end else if (accept && (relock_cnt_q != 16'hFFFF)) begin
            relock_cnt_q <= relock_cnt_q + 16'd1;
        end
    end

    assign relock_cnt = relock_cnt_q;
`endif

endmodule

// File: tb/tb_sys_clk_div_gen.sv
// Self-checking bench for sys_clk_div_gen: directed steps followed by random
// configuration traffic, compared every cycle against an arithmetic model.
module tb_sys_clk_div_gen;

    localparam int NUM_CH = 3;
    localparam int DIV_W  = 16;
    localparam int LC     = 16;
    localparam int DEF    = 2;
    localparam int CH_W   = 2;

    logic              refclk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [DIV_W-1:0]  cfg_div = '0;
    logic [DIV_W-1:0]  cfg_phase = '0;
    logic              cfg_err;
    logic [NUM_CH-1:0] outclk;
    logic [NUM_CH-1:0] outclk_en;
    logic              locked;
`ifdef CLKGEN_RELOCK_CNT_EN
    logic [15:0]       relock_cnt;
`endif

    sys_clk_div_gen #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .LOCK_CYCLES (LC),
        .DEF_DIV     (DEF)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_phase (cfg_phase),
        .cfg_err   (cfg_err),
        .outclk    (outclk),
        .outclk_en (outclk_en),
        .locked    (locked)
`ifdef CLKGEN_RELOCK_CNT_EN
        ,
        .relock_cnt (relock_cnt)
`endif
    );

    always #5 refclk = ~refclk;

    // Model: n counts rising edges; L is the edge at which the current
    // configuration epoch is loaded. Outputs of an epoch follow from (n - L).
    int n = 0;
    int L = 1;
    int prev_l = 0;
    bit prev_valid = 1'b0;
    int cur_div [NUM_CH];
    int cur_ph  [NUM_CH];
    int prv_div [NUM_CH];
    int prv_ph  [NUM_CH];
    bit exp_ready = 1'b0;
    bit exp_err = 1'b0;
    int exp_relock = 0;
    int n_assert = 0;
    int n_fail = 0;

    task automatic decode(input int div, input int ph, input int lx, input int nn,
                          output bit clk_o, output bit en_o);
        int m;
        int r;
        clk_o = 1'b0;
        en_o  = 1'b0;
        if (nn > lx) begin
            m = nn - lx - 1;
            r = ((m % div) + div - ph) % div;
            en_o  = (r == 0);
            clk_o = (r < div / 2);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, n, obs, exp);
        end
    endtask

    task automatic step();
        logic [NUM_CH-1:0] e_clk;
        logic [NUM_CH-1:0] e_en;
        bit c;
        bit e;
        int ch;
        @(posedge refclk);
        n++;
        exp_err = 1'b0;
        if (rst) begin
            L = n + 1;
            prev_valid = 1'b0;
            exp_relock = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                cur_div[i] = DEF;
                cur_ph[i]  = 0;
            end
        end else if (cfg_valid && exp_ready) begin
            ch = int'(cfg_ch);
            if (cfg_div >= 2 && cfg_phase < cfg_div && ch < NUM_CH) begin
                prev_l = L;
                prev_valid = 1'b1;
                for (int i = 0; i < NUM_CH; i++) begin
                    prv_div[i] = cur_div[i];
                    prv_ph[i]  = cur_ph[i];
                end
                cur_div[ch] = int'(cfg_div);
                cur_ph[ch]  = int'(cfg_phase);
                L = n + 1;
                if (exp_relock < 16'hFFFF) exp_relock++;
            end else begin
                exp_err = 1'b1;
            end
        end
        exp_ready = (n != L - 1);
        for (int i = 0; i < NUM_CH; i++) begin
            c = 1'b0;
            e = 1'b0;
            if (n >= L) decode(cur_div[i], cur_ph[i], L, n, c, e);
            else if (prev_valid) decode(prv_div[i], prv_ph[i], prev_l, n, c, e);
            e_clk[i] = c;
            e_en[i]  = e;
        end
        #1;
        check("outclk", 32'(outclk), 32'(e_clk));
        check("outclk_en", 32'(outclk_en), 32'(e_en));
        check("locked", 32'(locked), 32'(n >= L + LC));
        check("cfg_ready", 32'(cfg_ready), 32'(exp_ready));
        check("cfg_err", 32'(cfg_err), 32'(exp_err));
`ifdef CLKGEN_RELOCK_CNT_EN
        check("relock_cnt", 32'(relock_cnt), 32'(exp_relock));
`endif
    endtask

    task automatic idle(input int k);
        repeat (k) step();
    endtask

    task automatic cfg(input int ch, input int div, input int ph);
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_div   = DIV_W'(div);
        cfg_phase = DIV_W'(ph);
        step();
        cfg_valid = 1'b0;
        $display("cfg ch=%0d div=%0d phase=%0d -> err=%0b ready_next=%0b edge=%0d",
                 ch, div, ph, cfg_err, cfg_ready, n);
    endtask

    initial begin
        int guard;
        // 1: reset and default dividers, lock timing
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(LC + 6);

        // 2: channel 1 to div 5, phase 2
        cfg(1, 5, 2);
        idle(LC + 12);

        // 3: illegal requests while locked
        cfg(0, 1, 0);
        idle(3);
        cfg(1, 4, 4);
        idle(3);
        cfg(3, 4, 0);
        idle(8);

        // 4: legal request landing on the lock-completion edge
        cfg(0, 6, 0);
        guard = 0;
        while (n != L + LC - 1 && guard < 200) begin
            step();
            guard++;
        end
        cfg(2, 3, 1);
        idle(LC + 8);

        // 5: reset pulse while locked with div 7
        cfg(0, 7, 3);
        idle(LC + 4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle(LC + 10);

        // 6: mixed legal and illegal traffic, then random traffic
        cfg(0, 3, 0);
        idle(2);
        cfg(1, 0, 0);
        idle(2);
        cfg(1, 9, 8);
        idle(2);
        cfg(2, 4, 1);
        idle(LC + 4);

        repeat (40) begin
            idle($urandom_range(0, 30));
            cfg($urandom_range(0, 3), $urandom_range(0, 12), $urandom_range(0, 12));
        end
        idle(LC + 10);

        rst = 1'b1;
        step();
        rst = 1'b0;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
